// File: rtl/ppg_pkg.sv
// ============================================================================
// Module   : ppg_pkg
// Brief    : Shared widths, spodata field offsets and FSM states for the
//            SpO2 ratio producer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ppg_pkg;

    localparam int SAMPLE_W = 18;

    localparam int RED_MSB  = 35;
    localparam int RED_LSB  = 18;
    localparam int IR_MSB   = 17;
    localparam int IR_LSB   = 0;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ppg_minmax_acc.sv
// ============================================================================
// Module   : ppg_minmax_acc
// Brief    : Running max/min (and optional sum) over a sample window, with the
//            final values including the current sample exposed combinationally.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppg_minmax_acc
    import ppg_pkg::*;
#(
    parameter int SUM_W  = 18,
    parameter bit EN_SUM = 1'b1
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_de,
    input  logic                first,
    output logic [SAMPLE_W-1:0] max_fin,
    output logic [SAMPLE_W-1:0] min_fin,
    output logic [SUM_W-1:0]    sum_fin
);

    logic [SAMPLE_W-1:0] r_max;
    logic [SAMPLE_W-1:0] r_min;

    // First sample of a window reloads; otherwise strict compares so ties keep the old value.
    assign max_fin = (first || (sample > r_max)) ? sample : r_max;
    assign min_fin = (first || (sample < r_min)) ? sample : r_min;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max <= '0;
            r_min <= '0;
        end else if (sample_de) begin
            r_max <= max_fin;
            r_min <= min_fin;
        end
    end

    generate
        if (EN_SUM) begin : g_sum
            logic [SUM_W-1:0] r_sum;

            assign sum_fin = first ? SUM_W'(sample) : (r_sum + SUM_W'(sample));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sum <= '0;
                end else if (sample_de) begin
                    r_sum <= sum_fin;
                end
            end
        end else begin : g_no_sum
            assign sum_fin = '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/ppg_ratio_gen.sv
// ============================================================================
// Module   : ppg_ratio_gen
// Brief    : Windowed red/IR peak-to-peak and IR DC measurement; emits one
//            {red_ac, ir_ac} word per valid window after a settle period.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppg_ratio_gen
    import ppg_pkg::*;
#(
    parameter int unsigned         WIN_LEN    = 128,
    parameter int unsigned         SETTLE_WIN = 2,
    parameter logic [SAMPLE_W-1:0] DC_MIN     = 18'd1000,
    parameter logic [SAMPLE_W-1:0] AC_MIN     = 18'd4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SAMPLE_W-1:0]   sample_red,
    input  logic [SAMPLE_W-1:0]   sample_ir,
    input  logic                  sample_de,
    output logic [2*SAMPLE_W-1:0] spodata,
    output logic                  spodata_de,
    output logic                  finger_off
);

    localparam int               CNT_W       = $clog2(WIN_LEN);
    localparam int               SUM_W       = SAMPLE_W + CNT_W;
    localparam int               ST_W        = (SETTLE_WIN < 2) ? 1 : $clog2(SETTLE_WIN + 1);
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(WIN_LEN - 1);
    localparam state_t           c_rst_state = (SETTLE_WIN == 0) ? RUN : SETTLE;

    logic [CNT_W-1:0]    r_cnt;
    logic                w_first;
    logic                w_last;

    logic [SAMPLE_W-1:0] w_red_max;
    logic [SAMPLE_W-1:0] w_red_min;
    logic [SAMPLE_W-1:0] w_ir_max;
    logic [SAMPLE_W-1:0] w_ir_min;
    logic [SUM_W-1:0]    w_ir_sum;
    logic [SUM_W-1:0]    w_red_sum_unused;

    logic [SAMPLE_W-1:0] r_red_ac;
    logic [SAMPLE_W-1:0] r_ir_ac;
    logic [SAMPLE_W-1:0] r_ir_dc;
    logic                r_eval_pend;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ST_W-1:0]     r_settle_cnt;
    logic [ST_W-1:0]     w_settle_nxt;
    logic                w_dc_low;
    logic                w_valid;
    logic                w_emit;

    assign w_first = (r_cnt == '0);
    assign w_last  = sample_de && (r_cnt == c_cnt_last);

    ppg_minmax_acc #(
        .SUM_W  (SUM_W),
        .EN_SUM (1'b0)
    ) u_red_acc (
        .clk       (clk),
        .rst       (rst),
        .sample    (sample_red),
        .sample_de (sample_de),
        .first     (w_first),
        .max_fin   (w_red_max),
        .min_fin   (w_red_min),
        .sum_fin   (w_red_sum_unused)
    );

    ppg_minmax_acc #(
        .SUM_W  (SUM_W),
        .EN_SUM (1'b1)
    ) u_ir_acc (
        .clk       (clk),
        .rst       (rst),
        .sample    (sample_ir),
        .sample_de (sample_de),
        .first     (w_first),
        .max_fin   (w_ir_max),
        .min_fin   (w_ir_min),
        .sum_fin   (w_ir_sum)
    );

    // Window length is a power of two, so the counter wraps on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (sample_de) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_red_ac    <= '0;
            r_ir_ac     <= '0;
            r_ir_dc     <= '0;
            r_eval_pend <= 1'b0;
        end else begin
            r_eval_pend <= w_last;
            if (w_last) begin
                r_red_ac <= w_red_max - w_red_min;
                r_ir_ac  <= w_ir_max - w_ir_min;
                r_ir_dc  <= w_ir_sum[SUM_W-1:CNT_W];
            end
        end
    end

    assign w_dc_low = (r_ir_dc < DC_MIN);
    assign w_valid  = !w_dc_low && (r_ir_ac >= AC_MIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_rst_state;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        w_emit       = 1'b0;
        if (r_eval_pend) begin
            case (r_state)
                SETTLE: begin
                    if (w_dc_low) begin
                        w_settle_nxt = '0;
                    end else if ((32'(r_settle_cnt) + 32'd1) >= SETTLE_WIN) begin
                        w_state_nxt  = RUN;
                        w_settle_nxt = '0;
                    end else begin
                        w_settle_nxt = r_settle_cnt + ST_W'(1);
                    end
                end
                RUN: begin
                    if (w_dc_low) begin
                        w_state_nxt  = c_rst_state;
                        w_settle_nxt = '0;
                    end else begin
                        w_emit = w_valid;
                    end
                end
                default: begin
                    w_state_nxt  = c_rst_state;
                    w_settle_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spodata    <= '0;
            spodata_de <= 1'b0;
            finger_off <= 1'b1;
        end else begin
            spodata_de <= w_emit;
            if (w_emit) begin
                spodata[RED_MSB:RED_LSB] <= r_red_ac;
                spodata[IR_MSB:IR_LSB]   <= r_ir_ac;
            end
            if (r_eval_pend) begin
                finger_off <= w_dc_low;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ppg_ratio_gen.sv
// ============================================================================
// Module   : tb_ppg_ratio_gen
// Brief    : Directed self-checking bench for ppg_ratio_gen (WIN_LEN=4,
//            SETTLE_WIN=1, DC_MIN=1000, AC_MIN=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ppg_ratio_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] sample_red = '0;
    logic [17:0] sample_ir  = '0;
    logic        sample_de  = 1'b0;
    logic [35:0] spodata;
    logic        spodata_de;
    logic        finger_off;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          nstr  = 0;
    logic [35:0] sdata [64];
    int          scyc  [64];

    localparam logic [71:0] c_r_a   = {18'd2000, 18'd2100, 18'd2050, 18'd2000};
    localparam logic [71:0] c_i_a   = {18'd3000, 18'd3200, 18'd3100, 18'd3000};
    localparam logic [71:0] c_i_low = {18'd3000, 18'd3002, 18'd3001, 18'd3000};
    localparam logic [71:0] c_i_off = {18'd500,  18'd510,  18'd505,  18'd500};
    localparam logic [71:0] c_r_c   = {18'd1000, 18'd1300, 18'd1100, 18'd1200};
    localparam logic [71:0] c_r_b   = {18'd5000, 18'd4000, 18'd4500, 18'd4200};
    localparam logic [71:0] c_i_b   = {18'd2000, 18'd2600, 18'd2100, 18'd2300};
    localparam logic [35:0] c_d_a   = {18'd100,  18'd200};
    localparam logic [35:0] c_d_c   = {18'd300,  18'd200};
    localparam logic [35:0] c_d_b   = {18'd1000, 18'd600};

    ppg_ratio_gen #(
        .WIN_LEN    (4),
        .SETTLE_WIN (1),
        .DC_MIN     (18'd1000),
        .AC_MIN     (18'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_red (sample_red),
        .sample_ir  (sample_ir),
        .sample_de  (sample_de),
        .spodata    (spodata),
        .spodata_de (spodata_de),
        .finger_off (finger_off)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Log every strobe with the cycle it was seen in.
    always @(negedge clk) begin
        if (spodata_de === 1'b1) begin
            if (nstr < 64) begin
                sdata[nstr] = spodata;
                scyc[nstr]  = cyc;
            end
            nstr++;
        end
    end

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [17:0] r, input logic [17:0] i);
        sample_red = r;
        sample_ir  = i;
        sample_de  = 1'b1;
        @(negedge clk);
        sample_de  = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_de = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic win(input logic [71:0] r, input logic [71:0] i);
        for (int k = 0; k < 4; k++) begin
            put(r[71-18*k -: 18], i[71-18*k -: 18]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int c0;
        int cl;
        int gaps [4];
        gaps = '{7, 0, 3, 5};

        repeat (3) @(negedge clk);
        chk("rst_spodata", spodata, 36'd0);
        chk("rst_de", 36'(spodata_de), 36'd0);
        chk("rst_finger_off", 36'(finger_off), 36'd1);
        rst = 1'b0;
        @(negedge clk);

        // Settle window: discarded, finger_off clears
        win(c_r_a, c_i_a);
        idle(3);
        chk("w1_no_strobe", 36'(nstr), 36'd0);
        chk("w1_finger_off", 36'(finger_off), 36'd0);

        // First emitted window and its latency
        base = nstr;
        c0   = cyc;
        win(c_r_a, c_i_a);
        idle(3);
        chk("w2_strobes", 36'(nstr), 36'(base + 1));
        chk("w2_data", sdata[base], c_d_a);
        chk("w2_latency", 36'(scyc[base] - c0), 36'd5);
        chk("w2_hold", spodata, c_d_a);

        // Low AC: no strobe, stays RUN
        base = nstr;
        win(c_r_a, c_i_low);
        idle(3);
        chk("lowac_no_strobe", 36'(nstr), 36'(base));
        chk("lowac_finger_off", 36'(finger_off), 36'd0);
        win(c_r_c, c_i_a);
        idle(3);
        chk("lowac_run_strobes", 36'(nstr), 36'(base + 1));
        chk("lowac_run_data", sdata[base], c_d_c);

        // Finger-off: back to SETTLE, next good window discarded
        base = nstr;
        win(c_r_a, c_i_off);
        idle(3);
        chk("off_finger_off", 36'(finger_off), 36'd1);
        chk("off_no_strobe", 36'(nstr), 36'(base));
        win(c_r_a, c_i_a);
        idle(3);
        chk("off_settle_no_strobe", 36'(nstr), 36'(base));
        chk("off_settle_finger", 36'(finger_off), 36'd0);
        win(c_r_c, c_i_a);
        idle(3);
        chk("off_recover_strobes", 36'(nstr), 36'(base + 1));
        chk("off_recover_data", sdata[base], c_d_c);

        // Back-to-back: 8 consecutive samples, no drop at the window seam
        base = nstr;
        c0   = cyc;
        win(c_r_a, c_i_a);
        win(c_r_b, c_i_b);
        idle(3);
        chk("b2b_strobes", 36'(nstr), 36'(base + 2));
        chk("b2b_data0", sdata[base], c_d_a);
        chk("b2b_data1", sdata[base + 1], c_d_b);
        chk("b2b_cyc0", 36'(scyc[base] - c0), 36'd5);
        chk("b2b_cyc1", 36'(scyc[base + 1] - c0), 36'd9);

        // Gapped input gives the same result as back-to-back
        base = nstr;
        cl   = 0;
        idle(5);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) cl = cyc;
            put(c_r_b[71-18*k -: 18], c_i_b[71-18*k -: 18]);
            idle(gaps[k]);
        end
        idle(3);
        chk("gap_strobes", 36'(nstr), 36'(base + 1));
        chk("gap_data", sdata[base], c_d_b);
        chk("gap_latency", 36'(scyc[base] - cl), 36'd2);

        // Reset mid-window, with a sample coincident with rst
        put(c_r_a[71:54], c_i_a[71:54]);
        put(c_r_a[53:36], c_i_a[53:36]);
        sample_red = 18'd9000;
        sample_ir  = 18'd9000;
        sample_de  = 1'b1;
        rst        = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        sample_de  = 1'b0;
        chk("mid_rst_spodata", spodata, 36'd0);
        chk("mid_rst_de", 36'(spodata_de), 36'd0);
        chk("mid_rst_finger_off", 36'(finger_off), 36'd1);
        base = nstr;
        win(c_r_a, c_i_a);
        idle(3);
        chk("mid_rst_settle_no_strobe", 36'(nstr), 36'(base));
        win(c_r_c, c_i_a);
        idle(3);
        chk("mid_rst_recover_strobes", 36'(nstr), 36'(base + 1));
        chk("mid_rst_recover_data", sdata[base], c_d_c);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ppg_ratio_gen.md
Name: ppg_ratio_gen

Overview:
- Producer side of the SpO2 ratio interface. Sits between the PPG sensor sample reader and the SpO2 calculation block.
- Takes paired red/IR samples and measures peak-to-peak AC amplitude and mean IR DC level over fixed windows.
- Once per valid window, emits a one-cycle {red_ac, ir_ac} word with a strobe. The downstream block divides red_ac by ir_ac.
- Also flags finger-off and suppresses output while the sensor settles.

Parameters:
- WIN_LEN, 128: samples per window; power of two, 4..1024.
- SETTLE_WIN, 2: windows discarded after reset or finger-off recovery.
- DC_MIN, 18'd1000: IR mean below this level means finger-off.
- AC_MIN, 18'd4: IR peak-to-peak below this level makes the window invalid; must be at least 1 (divisor guard).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- sample_red, input, 18: red channel sample, unsigned.
- sample_ir, input, 18: IR channel sample, unsigned.
- sample_de, input, 1: sample pair valid, one cycle per pair; back-to-back allowed.
- spodata, output, 36: [35:18] = red_ac (dividend), [17:0] = ir_ac (divisor).
- spodata_de, output, 1: one-cycle strobe; spodata is valid only in this cycle.
- finger_off, output, 1: level; high while the last evaluated window's IR mean is below DC_MIN.

Behaviour:
- Interface: one clock domain (clk). Reset rst is synchronous and active-high.
- Reset values: spodata=0, spodata_de=0, finger_off=1. Accumulators, counters and FSM clear; state is SETTLE with settle_cnt=0.
- Accumulation, on each sample_de:
  - If cnt==0, load red_max, red_min, ir_max, ir_min from the sample and set ir_sum=sample_ir.
  - Otherwise update max/min with unsigned compares (ties keep the value) and add sample_ir to ir_sum.
  - ir_sum width is 18+log2(WIN_LEN), so it never overflows.
  - cnt increments and wraps to 0 after WIN_LEN-1.
- Window end: sample_de with cnt==WIN_LEN-1.
  - Final max/min/sum include this sample, merged combinationally.
  - Register snapshot: red_ac = red_max-red_min, ir_ac = ir_max-ir_min (18 bits; max>=min, so no underflow), ir_dc = ir_sum>>log2(WIN_LEN).
  - Raise internal eval_pend for one cycle. No sample is ever dropped; a sample_de in the next cycle starts the new window at cnt==0.
- Evaluation, in the cycle after window end:
  - finger_off <= (ir_dc < DC_MIN).
  - valid = !(ir_dc < DC_MIN) && (ir_ac >= AC_MIN).
  - spodata_de asserts only when valid and the state is RUN.
  - spodata updates only when spodata_de asserts, and holds otherwise.
- Latency: spodata_de is high exactly one cycle after the clock edge that captures the window's last sample.
- FSM:
  - SETTLE: each evaluated window with DC >= DC_MIN increments settle_cnt. At SETTLE_WIN, go to RUN and clear settle_cnt. That window is not emitted. A finger-off window clears settle_cnt.
  - RUN: emit valid windows. A finger-off window sends the FSM back to SETTLE with settle_cnt=0. A low-AC window alone keeps RUN.
  - SETTLE_WIN=0: the FSM enters RUN directly after reset.
- Reset mid-window: the partial window is discarded; no strobe follows reset.
- rst and sample_de in the same cycle: reset wins; the sample is ignored.
- sample_de gaps of any length are allowed; windows count samples, not cycles.

Decomposition:
- Shared package ppg_pkg holds: sample width (18), the spodata field offsets (RED_MSB=35, RED_LSB=18, IR_MSB=17, IR_LSB=0), and the FSM state enum {SETTLE, RUN}.
- One sub-module, ppg_minmax_acc, instantiated twice (red, IR). It provides running max/min plus the combinational final value, with an optional sum output used only on the IR instance.
- The top level holds the counter, snapshot, evaluation and FSM.

Test Plan (WIN_LEN=4, SETTLE_WIN=1, DC_MIN=1000, AC_MIN=4):
- Settle then emit:
  - Window 1 (discarded), red {2000,2100,2050,2000}, IR {3000,3200,3100,3000} -> no strobe; FSM enters RUN; finger_off falls to 0.
  - Window 2, same samples -> spodata={18'd100,18'd200} and spodata_de high exactly one cycle after the 4th sample.
- Finger-off: in RUN, IR {500,510,505,500} -> finger_off=1, no strobe, FSM to SETTLE. The next good window is discarded; the one after it emits.
- Low AC: in RUN, IR {3000,3002,3001,3000} -> no strobe, finger_off=0, FSM stays RUN.
- Back-to-back samples: 8 consecutive sample_de cycles in RUN -> two strobes, at cycles 5 and 9. The 5th sample lands in the second window's min/max (no drop).
- Reset mid-window: rst after 2 samples, then 4 good samples -> no strobe (SETTLE). All outputs read their reset values the cycle after rst.
- Gapped input: samples spaced 0 to 7 idle cycles apart -> same spodata as the back-to-back case for identical sample values.
